// File: rtl/bist_pkg.sv
// Shared types and helpers for the logic-BIST engine: FSM states, the Galois
// shift step used by both the pattern LFSR and the response MISR, and counter sizing.
package bist_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    CAPTURE,
    UNLOAD,
    COMPARE,
    DONE
  } bist_state_e;

  // Width needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // One Galois step of a w-bit register held in the low bits of a MAX_W vector.
  function automatic logic [MAX_W-1:0] galois_step(input logic [MAX_W-1:0] val,
                                                   input logic [MAX_W-1:0] poly,
                                                   input int unsigned      w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] nxt;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    top  = val >> (w - 1);
    nxt  = (val << 1) & mask;
    if (top[0]) nxt = nxt ^ (poly & mask);
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_misr_core.sv
// Galois shift register with synchronous load of INIT_VAL, step enable and a
// data word folded in on every step; serves as both pattern LFSR and signature MISR.
module lfsr_misr_core
  import bist_pkg::*;
#(
  parameter int unsigned     W        = 8,
  parameter logic [W-1:0]    POLY     = '0,
  parameter logic [W-1:0]    INIT_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = INIT_VAL;
    end else if (en_i) begin
      q_d = W'(galois_step(MAX_W'(q_q), MAX_W'(POLY), W)) ^ data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= INIT_VAL;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

  if (W < 2 || W > MAX_W) begin : g_bad_width
    $error("lfsr_misr_core: W must lie in 2..MAX_W");
  end

endmodule

// File: rtl/param_bist_engine.sv
// Logic-BIST engine: LFSR-driven scan/functional stimulus, shift/capture/unload
// sequencing over N_PATTERNS, MISR compaction and golden-signature compare.
module param_bist_engine
  import bist_pkg::*;
#(
  parameter int unsigned          N_IN       = 3,
  parameter int unsigned          N_OUT      = 2,
  parameter int unsigned          LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]    LFSR_POLY  = 8'h1D,
  parameter logic [LFSR_W-1:0]    LFSR_SEED  = 8'h01,
  parameter int unsigned          MISR_W     = 8,
  parameter logic [MISR_W-1:0]    MISR_POLY  = 8'h1D,
  parameter int unsigned          CHAIN_LEN  = 16,
  parameter int unsigned          N_PATTERNS = 64,
  parameter logic [MISR_W-1:0]    GOLDEN_SIG = 8'h00,
  localparam int unsigned         PCNT_W     = cnt_width(N_PATTERNS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bist_start,
  input  logic              bist_abort,
  input  logic              scan_out,
  input  logic [N_OUT-1:0]  func_out,
  output logic              scan_en,
  output logic              scan_in,
  output logic [N_IN-1:0]   func_in,
  output logic              bist_busy,
  output logic              bist_end,
  output logic              pass_fail,
  output logic [MISR_W-1:0] signature,
  output logic [PCNT_W-1:0] pattern_cnt
);

  localparam int unsigned         SCNT_W     = cnt_width(CHAIN_LEN);
  localparam logic [SCNT_W-1:0]   SHIFT_LAST = SCNT_W'(CHAIN_LEN - 1);
  localparam logic [PCNT_W-1:0]   PCNT_LAST  = PCNT_W'(N_PATTERNS);

  bist_state_e       state_q, state_d;
  logic [SCNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [PCNT_W-1:0] pattern_cnt_q, pattern_cnt_d;
  logic              busy_q, busy_d;
  logic              end_q, end_d;
  logic              pass_q, pass_d;

  logic              lfsr_en, lfsr_load;
  logic              misr_en, misr_load;
  logic [MISR_W-1:0] misr_data;
  logic [LFSR_W-1:0] lfsr_q;
  logic [MISR_W-1:0] misr_q;
  logic              unused_lfsr;

  lfsr_misr_core #(
    .W        (LFSR_W),
    .POLY     (LFSR_POLY),
    .INIT_VAL (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (CLK),
    .rst_ni (RST),
    .en_i   (lfsr_en),
    .load_i (lfsr_load),
    .data_i ('0),
    .q_o    (lfsr_q)
  );

  lfsr_misr_core #(
    .W        (MISR_W),
    .POLY     (MISR_POLY),
    .INIT_VAL ('0)
  ) u_misr (
    .clk_i  (CLK),
    .rst_ni (RST),
    .en_i   (misr_en),
    .load_i (misr_load),
    .data_i (misr_data),
    .q_o    (misr_q)
  );

  always_comb begin
    state_d       = state_q;
    shift_cnt_d   = shift_cnt_q;
    pattern_cnt_d = pattern_cnt_q;
    end_d         = end_q;
    pass_d        = pass_q;
    lfsr_en       = 1'b0;
    lfsr_load     = 1'b0;
    misr_en       = 1'b0;
    misr_load     = 1'b0;
    misr_data     = '0;

    case (state_q)
      IDLE, DONE: begin
        if (bist_start) begin
          state_d = INIT;
          end_d   = 1'b0;
          pass_d  = 1'b0;
        end
      end
      INIT: begin
        lfsr_load     = 1'b1;
        misr_load     = 1'b1;
        pattern_cnt_d = '0;
        shift_cnt_d   = '0;
        state_d       = SHIFT;
      end
      SHIFT: begin
        lfsr_en = 1'b1;
        // Pattern 0 unloads whatever the chain held before the run: keep it out.
        if (pattern_cnt_q != '0) begin
          misr_en   = 1'b1;
          misr_data = MISR_W'(scan_out);
        end
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
          state_d     = CAPTURE;
        end else begin
          shift_cnt_d = shift_cnt_q + SCNT_W'(1);
        end
      end
      CAPTURE: begin
        lfsr_en       = 1'b1;
        misr_en       = 1'b1;
        misr_data     = MISR_W'({func_out, 1'b0});
        pattern_cnt_d = pattern_cnt_q + PCNT_W'(1);
        state_d       = (pattern_cnt_d == PCNT_LAST) ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        misr_en   = 1'b1;
        misr_data = MISR_W'(scan_out);
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
          state_d     = COMPARE;
        end else begin
          shift_cnt_d = shift_cnt_q + SCNT_W'(1);
        end
      end
      COMPARE: begin
        pass_d  = (misr_q == GOLDEN_SIG);
        end_d   = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every transition; registers hold so the run state is frozen.
    if (bist_abort && busy_q) begin
      state_d       = IDLE;
      end_d         = 1'b0;
      pass_d        = 1'b0;
      shift_cnt_d   = shift_cnt_q;
      pattern_cnt_d = pattern_cnt_q;
      lfsr_en       = 1'b0;
      lfsr_load     = 1'b0;
      misr_en       = 1'b0;
      misr_load     = 1'b0;
    end

    busy_d = (state_d == INIT) || (state_d == SHIFT) || (state_d == CAPTURE) ||
             (state_d == UNLOAD) || (state_d == COMPARE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      shift_cnt_q   <= '0;
      pattern_cnt_q <= '0;
      busy_q        <= 1'b0;
      end_q         <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_cnt_q   <= shift_cnt_d;
      pattern_cnt_q <= pattern_cnt_d;
      busy_q        <= busy_d;
      end_q         <= end_d;
      pass_q        <= pass_d;
    end
  end

  assign scan_en     = (state_q == SHIFT) || (state_q == UNLOAD);
  assign scan_in     = (state_q == SHIFT) && lfsr_q[0];
  assign func_in     = busy_q ? lfsr_q[N_IN-1:0] : '0;
  assign bist_busy   = busy_q;
  assign bist_end    = end_q;
  assign pass_fail   = pass_q;
  assign signature   = misr_q;
  assign pattern_cnt = pattern_cnt_q;
  assign unused_lfsr = ^lfsr_q;

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("param_bist_engine: LFSR_SEED must be nonzero");
  end
  if (LFSR_W < N_IN) begin : g_bad_lfsr_w
    $error("param_bist_engine: LFSR_W must be >= N_IN");
  end
  if (MISR_W < N_OUT + 1) begin : g_bad_misr_w
    $error("param_bist_engine: MISR_W must be >= N_OUT+1");
  end
  if (CHAIN_LEN < 1 || N_PATTERNS < 1) begin : g_bad_len
    $error("param_bist_engine: CHAIN_LEN and N_PATTERNS must be >= 1");
  end

endmodule

// File: doc/param_bist_engine.md
Name: param_bist_engine

Overview:
Parametrised logic-BIST engine, the successor of the fixed 3-bit LFSR / BIST-control / MISR / comparator group. It drives one scan chain and a functional input vector of configurable width with LFSR patterns, and sequences shift/capture/unload for a configurable pattern count. It compacts scan and functional responses in a MISR of configurable width and compares the result against a golden signature. It sits between the top-level pin mux and the scan-inserted core, and adds abort, busy, pattern-count and signature-readout capability.

Parameters:
N_IN, 3, width of functional test vector func_in
N_OUT, 2, width of functional response func_out
LFSR_W, 8, LFSR width (LFSR_W >= N_IN)
LFSR_POLY, 8'h1D, Galois feedback mask
LFSR_SEED, 8'h01, LFSR reset/INIT value (nonzero)
MISR_W, 8, MISR width (MISR_W >= N_OUT+1)
MISR_POLY, 8'h1D, MISR Galois feedback mask
CHAIN_LEN, 16, scan chain length (>= 1)
N_PATTERNS, 64, pattern count (>= 1)
GOLDEN_SIG, 8'h00, expected final signature

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low
bist_start  in  1  start request, sampled in IDLE only
bist_abort  in  1  abort request, sampled in any busy state
scan_out  in  1  scan chain output from core
func_out  in  N_OUT  core functional outputs
scan_en  out  1  scan shift enable (also selects test inputs in the top-level mux)
scan_in  out  1  scan chain input
func_in  out  N_IN  test vector to the top-level mux
bist_busy  out  1  run in progress
bist_end  out  1  run completed
pass_fail  out  1  1 = signature matched
signature  out  MISR_W  current MISR contents
pattern_cnt  out  clog2(N_PATTERNS+1)  patterns captured so far

Behaviour:
- Reset (RST=0, async): state IDLE; lfsr=LFSR_SEED; misr=0; all counters 0; every output 0.
- States: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
- IDLE/DONE: on bist_start=1, go to INIT next cycle and clear bist_end and pass_fail. In any other state, bist_start is ignored.
- INIT (1 cycle): lfsr<=LFSR_SEED, misr<=0, pattern_cnt<=0, shift count<=0; then SHIFT.
- SHIFT (CHAIN_LEN cycles): scan_en=1; scan_in=lfsr[0]; lfsr advances each cycle. The MISR absorbs scan_out only when pattern_cnt>0, because pattern 0 unloads an uninitialised chain. After CHAIN_LEN cycles, go to CAPTURE.
- CAPTURE (1 cycle): scan_en=0; func_in=lfsr[N_IN-1:0] (func_in is also driven from the lfsr in other states, but is only meaningful here); MISR absorbs func_out; lfsr advances; pattern_cnt+1. If the new count equals N_PATTERNS, go to UNLOAD; otherwise go to SHIFT.
- UNLOAD (CHAIN_LEN cycles): scan_en=1, scan_in=0, lfsr holds, MISR absorbs scan_out; then COMPARE.
- COMPARE (1 cycle): pass_fail <= (misr == GOLDEN_SIG); then DONE.
- DONE: bist_end=1, and pass_fail and signature hold until the next start or reset.
- bist_busy=1 in INIT through COMPARE. The total run is 1 + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles, counted from the edge that samples bist_start to bist_end rising.
- LFSR step (Galois): next = {lfsr[W-2:0],1'b0} ^ (lfsr[W-1] ? LFSR_POLY : 0).
- MISR step: next = {misr[W-2:0],1'b0} ^ (misr[W-1] ? MISR_POLY : 0) ^ d.
  - d[0] = scan_out when absorbing a shift; otherwise 0.
  - d[N_OUT:1] = func_out in CAPTURE; otherwise 0.
  - All other bits of d are 0.
  - In non-absorbing cycles the MISR holds.
- Abort: bist_abort=1 in any busy state → IDLE next cycle; scan_en=0, bist_busy=0, bist_end=0, pass_fail=0. Abort has priority over every transition.
- Outputs scan_en, scan_in and func_in are combinational from state/lfsr. All other outputs are registered.
- Elaboration check: fail on LFSR_SEED==0, LFSR_W<N_IN, or MISR_W<N_OUT+1.

Decomposition:
- Shared package bist_pkg holds:
  - the state enum (IDLE…DONE);
  - a Galois-step function used by both LFSR and MISR;
  - a counter-width helper.
- Sub-module: lfsr_misr_core (parametrised Galois register with enable, load and data-xor input), instantiated twice.
- The FSM and counters stay in param_bist_engine.

Test Plan:
- Sequence check: LFSR_W=4, POLY=4'h3, SEED=4'h1, CHAIN_LEN=4, N_PATTERNS=2. Pulse start → scan_in in the first SHIFT is 1,0,0,0; func_in at the first CAPTURE is 3'h3 (lfsr=4'h3); bist_end rises 16 cycles after start is sampled.
- Zero response: scan_out=0 and func_out=0 throughout, GOLDEN_SIG=0 → signature=0, pass_fail=1, bist_end=1, pattern_cnt=N_PATTERNS.
- Mismatch: same config with func_out=2'b01 only at the first CAPTURE → signature nonzero (matches the bench reference model), pass_fail=0.
- Abort: assert bist_abort during the second SHIFT → next cycle IDLE, bist_busy=0, bist_end=0, pass_fail=0; a restart then completes normally with an identical signature.
- Ignore and async reset: start pulses while busy → no effect on timing or signature. Drive RST low mid-UNLOAD → all outputs 0 immediately, without waiting for a clock edge.
- Restart from DONE: bist_end and pass_fail clear on the start edge, and the second run reproduces the same signature.
